mvu_pe_popcount_acc: RTL

Consumer-side stage for the XNOR SIMD multiplier lanes of an MVU processing element. Each beat it takes one packed vector of SIMD XNOR products, counts the set product bits, and accumulates the count over SF beats (one synapse fold). It then emits the binary dot-product popcount on a valid/ready output. It sits between the SIMD multiplier lanes and the threshold/output stage of each PE.

---
 rtl/mvu_pe_pkg.sv | 12 +
 rtl/mvu_pe_popcount_acc_if.sv | 15 +
 rtl/mvu_pe_popcount.sv | 17 +
 rtl/mvu_pe_popcount_acc.sv | 47 ++++
 4 files changed

// File: rtl/mvu_pe_pkg.sv
// mvu_pe_pkg: shared widths, product vector type and parameter checks for the PE popcount stage
package mvu_pe_pkg;
  localparam int SIMD_DEF = 4;
  localparam int TDSTI_DEF = 4;
  typedef logic [SIMD_DEF*TDSTI_DEF-1:0] prod_vec_t;
  function automatic int acc_width(int simd, int sf);
    return $clog2(simd * sf + 1);
  endfunction
  function automatic bit params_ok(int simd, int sf, int taccw);
    return simd >= 1 && sf >= 1 && taccw >= acc_width(simd, sf);
  endfunction
endpackage

// File: rtl/mvu_pe_popcount_acc_if.sv
// mvu_pe_popcount_acc_if: product-vector input stream and popcount result stream
interface mvu_pe_popcount_acc_if #(
  parameter int SIMD = 4,
  parameter int TDstI = 4,
  parameter int TAccW = 6
);
  logic in_v;
  logic in_rdy;
  logic [SIMD*TDstI-1:0] in_prod;
  logic out_v;
  logic out_rdy;
  logic [TAccW-1:0] out_dat;
  modport master (output in_v, in_prod, out_rdy, input in_rdy, out_v, out_dat);
  modport slave (input in_v, in_prod, out_rdy, output in_rdy, out_v, out_dat);
endinterface

// File: rtl/mvu_pe_popcount.sv
// mvu_pe_popcount: counts the product bit (bit 0) of each SIMD lane
module mvu_pe_popcount #(
  parameter int SIMD = 4,
  parameter int TDstI = 4,
  parameter int CW = $clog2(SIMD + 1)
) (
  input  logic [SIMD*TDstI-1:0] prod,
  output logic [CW-1:0] cnt
);
  logic unused_upper;
  assign unused_upper = ^prod;
  // sum bit 0 of every lane; upper lane bits carry no product
  always_comb begin
    cnt = '0;
    for (int i = 0; i < SIMD; i++) cnt = cnt + CW'(prod[i*TDstI]);
  end
endmodule

// File: rtl/mvu_pe_popcount_acc.sv
// mvu_pe_popcount_acc: accumulates XNOR popcounts over one synapse fold and emits the dot product
module mvu_pe_popcount_acc
  import mvu_pe_pkg::*;
#(
  parameter int SIMD = 4,
  parameter int TDstI = 4,
  parameter int SF = 8,
  parameter int TAccW = acc_width(SIMD, SF)
) (
  input logic aclk,
  input logic rst,
  mvu_pe_popcount_acc_if.slave s
);
  localparam int CW = $clog2(SIMD + 1);
  localparam int SW = SF > 1 ? $clog2(SF) : 1;
  if (!params_ok(SIMD, SF, TAccW)) begin : g_bad_params
    $error("mvu_pe_popcount_acc: need SIMD>=1, SF>=1, TAccW>=acc_width(SIMD,SF)");
  end
  logic [CW-1:0] cnt;
  logic [SW-1:0] sf_cnt;
  logic [TAccW-1:0] acc, sum;
  logic last, take;
  mvu_pe_popcount #(.SIMD(SIMD), .TDstI(TDstI)) u_pc (.prod(s.in_prod), .cnt(cnt));
  // only the final beat of a fold waits for room in the result register
  always_comb begin
    last = sf_cnt == SW'(SF - 1);
    s.in_rdy = !last || !s.out_v || s.out_rdy;
    take = s.in_v && s.in_rdy;
    sum = (sf_cnt == '0 ? '0 : acc) + TAccW'(cnt);
  end
  // fold counter, running sum and result register; a drain and a new load may coincide
  always_ff @(posedge aclk) begin
    if (rst) begin
      sf_cnt <= '0;
      acc <= '0;
      s.out_v <= 1'b0;
      s.out_dat <= '0;
    end else begin
      if (take) begin
        sf_cnt <= last ? '0 : sf_cnt + SW'(1);
        acc <= sum;
      end
      if (take && last) s.out_dat <= sum;
      s.out_v <= (take && last) || (s.out_v && !s.out_rdy);
    end
  end
endmodule
